// File: rtl/tron_round_ctrl_pkg.sv
// Shared encodings for the Tron match logic: FSM states, head directions,
// round-winner codes and the default match length.
package tron_round_ctrl_pkg;

  typedef enum logic [1:0] {
    QI      = 2'b00,
    QGAME_1 = 2'b01,
    QGAME_2 = 2'b10,
    QDONE   = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_DRAW = 2'b11
  } winner_e;

  localparam int DEFAULT_WIN_SCORE = 10;

endpackage

// File: rtl/tron_round_ctrl_if.sv
// Status/control bundle between the collision stage, the round controller
// and the display logic.
interface tron_round_ctrl_if #(
  parameter int SCORE_W = 4
);
  logic               start;
  logic               tick;
  logic               p1_crash;
  logic               p2_crash;
  logic [1:0]         state;
  logic               run;
  logic               round_rst;
  logic [SCORE_W-1:0] p1_score;
  logic [SCORE_W-1:0] p2_score;
  logic [1:0]         round_winner;
  logic               p1_win;
  logic               p2_win;

  modport slave (
    input  start, tick, p1_crash, p2_crash,
    output state, run, round_rst, p1_score, p2_score, round_winner, p1_win, p2_win
  );

  modport master (
    output start, tick, p1_crash, p2_crash,
    input  state, run, round_rst, p1_score, p2_score, round_winner, p1_win, p2_win
  );
endinterface

// File: rtl/tron_round_ctrl_sync_edge.sv
// Two-flop synchroniser with a rising-edge pulse for asynchronous switch and
// button levels; the pulse lasts one clock per low-to-high transition.
module tron_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);
  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;
endmodule

// File: rtl/tron_round_ctrl.sv
// Match/round controller: resolves crashes on game ticks, keeps the score,
// freezes the arena between rounds and drives run/round_rst to the movers.
module tron_round_ctrl
  import tron_round_ctrl_pkg::*;
#(
  parameter int WIN_SCORE   = DEFAULT_WIN_SCORE,
  parameter int SCORE_W     = 4,
  parameter int PAUSE_TICKS = 64,
  parameter int PCNT_W      = 7
) (
  input  logic               board_clk,
  input  logic               reset,
  tron_round_ctrl_if.slave   bus
);
  localparam logic [SCORE_W-1:0] WIN_S    = SCORE_W'(WIN_SCORE);
  localparam logic [PCNT_W-1:0]  PAUSE_LD = PCNT_W'(PAUSE_TICKS);

  logic               start_lvl;
  logic               start_rise;
  state_e             state_q;
  logic               run_q;
  logic               round_rst_q;
  logic [SCORE_W-1:0] p1_score_q;
  logic [SCORE_W-1:0] p2_score_q;
  winner_e            winner_q;
  logic               p1_win_q;
  logic               p2_win_q;
  logic [PCNT_W-1:0]  pcnt_q;
  logic [SCORE_W-1:0] p1_score_d;
  logic [SCORE_W-1:0] p2_score_d;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    if (v >= WIN_S) return v;
    return v + 1'b1;
  endfunction

  tron_sync_edge u_start_sync (
    .clk_i   (board_clk),
    .rst_i   (reset),
    .async_i (bus.start),
    .level_o (start_lvl),
    .rise_o  (start_rise)
  );

  assign p1_score_d = sat_inc(p1_score_q);
  assign p2_score_d = sat_inc(p2_score_q);

  // Priority: start released, then start edge, then tick-driven events.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state_q     <= QI;
      run_q       <= 1'b0;
      round_rst_q <= 1'b0;
      p1_score_q  <= '0;
      p2_score_q  <= '0;
      winner_q    <= WIN_NONE;
      p1_win_q    <= 1'b0;
      p2_win_q    <= 1'b0;
      pcnt_q      <= '0;
    end else begin
      round_rst_q <= 1'b0;
      if (state_q != QI && !start_lvl) begin
        state_q  <= QI;
        run_q    <= 1'b0;
        p1_win_q <= 1'b0;
        p2_win_q <= 1'b0;
      end else if (start_rise && (state_q == QI || state_q == QDONE)) begin
        state_q     <= QGAME_1;
        run_q       <= 1'b1;
        round_rst_q <= 1'b1;
        p1_score_q  <= '0;
        p2_score_q  <= '0;
        winner_q    <= WIN_NONE;
        p1_win_q    <= 1'b0;
        p2_win_q    <= 1'b0;
      end else begin
        case (state_q)
          QGAME_1: begin
            if (bus.tick && (bus.p1_crash || bus.p2_crash)) begin
              run_q  <= 1'b0;
              pcnt_q <= PAUSE_LD;
              if (bus.p1_crash && bus.p2_crash) begin
                winner_q <= WIN_DRAW;
                state_q  <= QGAME_2;
              end else if (bus.p2_crash) begin
                p1_score_q <= p1_score_d;
                winner_q   <= WIN_P1;
                if (p1_score_d == WIN_S) begin
                  state_q  <= QDONE;
                  p1_win_q <= 1'b1;
                end else begin
                  state_q  <= QGAME_2;
                end
              end else begin
                p2_score_q <= p2_score_d;
                winner_q   <= WIN_P2;
                if (p2_score_d == WIN_S) begin
                  state_q  <= QDONE;
                  p2_win_q <= 1'b1;
                end else begin
                  state_q  <= QGAME_2;
                end
              end
            end
          end
          QGAME_2: begin
            if (bus.tick) begin
              // A count of 1 here is the tick that empties the pause.
              if (pcnt_q <= PCNT_W'(1)) begin
                pcnt_q      <= '0;
                state_q     <= QGAME_1;
                run_q       <= 1'b1;
                round_rst_q <= 1'b1;
              end else begin
                pcnt_q <= pcnt_q - 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.state        = state_q;
  assign bus.run          = run_q;
  assign bus.round_rst    = round_rst_q;
  assign bus.p1_score     = p1_score_q;
  assign bus.p2_score     = p2_score_q;
  assign bus.round_winner = winner_q;
  assign bus.p1_win       = p1_win_q;
  assign bus.p2_win       = p2_win_q;
endmodule

// File: tb/tb_tron_round_ctrl.sv
// Scoreboard bench for tron_round_ctrl: stimulus queues hand-computed
// expected outputs tagged with a cycle number, a monitor checks them.
module tb_tron_round_ctrl;
  logic board_clk;
  logic reset;
  int   cyc;
  int   vectors;
  int   miscompares;

  typedef struct {
    int         cyc;
    string      name;
    logic [1:0] st;
    logic       run;
    logic       rr;
    logic [3:0] p1;
    logic [3:0] p2;
    logic [1:0] win;
    logic       p1w;
    logic       p2w;
  } exp_t;

  exp_t exp_q[$];

  tron_round_ctrl_if #(.SCORE_W(4)) bus ();

  tron_round_ctrl #(
    .WIN_SCORE   (10),
    .SCORE_W     (4),
    .PAUSE_TICKS (64),
    .PCNT_W      (7)
  ) dut (
    .board_clk (board_clk),
    .reset     (reset),
    .bus       (bus)
  );

  initial begin
    board_clk = 1'b0;
    forever #5 board_clk = ~board_clk;
  end

  always @(posedge board_clk) cyc <= cyc + 1;

  // Monitor: compare every expectation whose cycle has come up.
  always @(negedge board_clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      if (e.cyc < cyc) begin
        miscompares++;
        $display("FAIL %s not checked in time: cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
      end else if (bus.state !== e.st || bus.run !== e.run || bus.round_rst !== e.rr ||
                   bus.p1_score !== e.p1 || bus.p2_score !== e.p2 ||
                   bus.round_winner !== e.win || bus.p1_win !== e.p1w || bus.p2_win !== e.p2w) begin
        miscompares++;
        $display("FAIL %s @%0d: got st=%0d run=%0d rr=%0d p1=%0d p2=%0d w=%0d p1w=%0d p2w=%0d; expected st=%0d run=%0d rr=%0d p1=%0d p2=%0d w=%0d p1w=%0d p2w=%0d",
                 e.name, cyc, bus.state, bus.run, bus.round_rst, bus.p1_score, bus.p2_score,
                 bus.round_winner, bus.p1_win, bus.p2_win,
                 e.st, e.run, e.rr, e.p1, e.p2, e.win, e.p1w, e.p2w);
      end
    end
  end

  task automatic expect_at(input int k, input string name, input logic [1:0] st,
                           input logic run, input logic rr, input logic [3:0] p1,
                           input logic [3:0] p2, input logic [1:0] win,
                           input logic p1w, input logic p2w);
    exp_t e;
    e.cyc = cyc + k; e.name = name; e.st = st; e.run = run; e.rr = rr;
    e.p1 = p1; e.p2 = p2; e.win = win; e.p1w = p1w; e.p2w = p2w;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge board_clk);
  endtask

  // Raise start from QI/QDONE; new match appears on the third edge.
  task automatic raise_start(input logic [1:0] prev_st, input logic [3:0] p1,
                             input logic [3:0] p2, input logic [1:0] win,
                             input logic p1w, input logic p2w);
    bus.start = 1'b1;
    expect_at(2, "start_sync", prev_st, 1'b0, 1'b0, p1, p2, win, p1w, p2w);
    expect_at(3, "start_go", 2'b01, 1'b1, 1'b1, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0);
    expect_at(4, "start_rr_pulse", 2'b01, 1'b1, 1'b0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0);
    step(4);
  endtask

  task automatic crash(input logic c1, input logic c2, input string name,
                       input logic [1:0] st, input logic [3:0] p1, input logic [3:0] p2,
                       input logic [1:0] win, input logic p1w, input logic p2w);
    bus.tick = 1'b1; bus.p1_crash = c1; bus.p2_crash = c2;
    expect_at(1, name, st, 1'b0, 1'b0, p1, p2, win, p1w, p2w);
    step(1);
    bus.tick = 1'b0; bus.p1_crash = 1'b0; bus.p2_crash = 1'b0;
    step(1);
  endtask

  // 64 ticks of pause, one every other cycle, with a crash that must be ignored.
  task automatic pause_round(input logic [3:0] p1, input logic [3:0] p2, input logic [1:0] win);
    for (int i = 0; i < 64; i++) begin
      bus.tick = 1'b1;
      if (i == 10) bus.p1_crash = 1'b1;
      if (i == 63)
        expect_at(1, "pause_resume", 2'b01, 1'b1, 1'b1, p1, p2, win, 1'b0, 1'b0);
      else if (i == 10 || i == 62)
        expect_at(1, "pause_hold", 2'b10, 1'b0, 1'b0, p1, p2, win, 1'b0, 1'b0);
      step(1);
      bus.tick = 1'b0; bus.p1_crash = 1'b0;
      if (i == 63)
        expect_at(1, "pause_rr_once", 2'b01, 1'b1, 1'b0, p1, p2, win, 1'b0, 1'b0);
      step(1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time %0t exceeded, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0; vectors = 0; miscompares = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.tick = 1'b0; bus.p1_crash = 1'b0; bus.p2_crash = 1'b0;
    step(2);
    expect_at(1, "reset_vals", 2'b00, 1'b0, 1'b0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0);
    step(1);
    reset = 1'b0;
    step(1);

    // Tick with crash in QI is ignored.
    bus.tick = 1'b1; bus.p2_crash = 1'b1;
    expect_at(1, "qi_tick_ignored", 2'b00, 1'b0, 1'b0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0);
    step(1);
    bus.tick = 1'b0; bus.p2_crash = 1'b0;
    step(1);

    raise_start(2'b00, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0);

    // Crash without tick does nothing.
    bus.p1_crash = 1'b1; bus.p2_crash = 1'b1;
    expect_at(1, "crash_no_tick", 2'b01, 1'b1, 1'b0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0);
    step(1);
    bus.p1_crash = 1'b0; bus.p2_crash = 1'b0;
    step(1);

    crash(1'b0, 1'b1, "p2_crash", 2'b10, 4'd1, 4'd0, 2'b01, 1'b0, 1'b0);
    pause_round(4'd1, 4'd0, 2'b01);
    crash(1'b1, 1'b1, "both_crash", 2'b10, 4'd1, 4'd0, 2'b11, 1'b0, 1'b0);
    pause_round(4'd1, 4'd0, 2'b11);
    crash(1'b1, 1'b0, "p1_crash", 2'b10, 4'd1, 4'd1, 2'b10, 1'b0, 1'b0);
    pause_round(4'd1, 4'd1, 2'b10);
    for (int s = 2; s <= 9; s++) begin
      crash(1'b0, 1'b1, "p1_scores", 2'b10, 4'(s), 4'd1, 2'b01, 1'b0, 1'b0);
      pause_round(4'(s), 4'd1, 2'b01);
    end

    crash(1'b0, 1'b1, "p1_wins", 2'b11, 4'd10, 4'd1, 2'b01, 1'b1, 1'b0);
    crash(1'b0, 1'b1, "done_saturate", 2'b11, 4'd10, 4'd1, 2'b01, 1'b1, 1'b0);

    bus.start = 1'b0;
    expect_at(2, "done_hold", 2'b11, 1'b0, 1'b0, 4'd10, 4'd1, 2'b01, 1'b1, 1'b0);
    expect_at(3, "done_to_qi", 2'b00, 1'b0, 1'b0, 4'd10, 4'd1, 2'b01, 1'b0, 1'b0);
    step(4);

    raise_start(2'b00, 4'd10, 4'd1, 2'b01, 1'b0, 1'b0);
    crash(1'b1, 1'b0, "m2_p1_crash", 2'b10, 4'd0, 4'd1, 2'b10, 1'b0, 1'b0);

    // Drop start mid-pause: QI, scores held, no round_rst.
    bus.start = 1'b0;
    expect_at(3, "pause_to_qi", 2'b00, 1'b0, 1'b0, 4'd0, 4'd1, 2'b10, 1'b0, 1'b0);
    expect_at(4, "qi_no_rr", 2'b00, 1'b0, 1'b0, 4'd0, 4'd1, 2'b10, 1'b0, 1'b0);
    step(5);
    raise_start(2'b00, 4'd0, 4'd1, 2'b10, 1'b0, 1'b0);

    for (int s = 1; s <= 3; s++) begin
      crash(1'b0, 1'b1, "m3_p1_scores", 2'b10, 4'(s), 4'd0, 2'b01, 1'b0, 1'b0);
      pause_round(4'(s), 4'd0, 2'b01);
    end

    // Asynchronous reset mid-cycle in QGAME_1 with p1_score=3.
    @(posedge board_clk);
    #1;
    reset = 1'b1;
    expect_at(0, "async_reset", 2'b00, 1'b0, 1'b0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0);
    step(1);
    reset = 1'b0;
    step(3);

    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_expectations: %0d left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
